// File: rtl/qemu_rd_cpl_assembler_if.sv
// Bus between the QEMU completion source / AR capture logic and the read-completion assembler.
// The master side drives requests and chunks; the slave side returns the assembled buffer and status.
interface qemu_rd_cpl_assembler_if #(
    parameter int TAGW = 3,
    parameter int CHW  = 64,
    parameter int DTMP = 4096
);
    logic                req_fire;
    logic [TAGW-1:0]     req_id;
    logic [7:0]          req_len;
    logic [2:0]          req_size;
    logic                cpl_valid;
    logic                cpl_ready;
    logic [TAGW-1:0]     cpl_id;
    logic [CHW-1:0]      cpl_data;
    logic [CHW/8-1:0]    cpl_keep;
    logic                cpl_last;
    logic [7:0]          req_data [DTMP];
    logic                req_valid;
    logic                busy;
    logic                err_id;
    logic                err_ovf;
    logic                err_tout;

    modport master (
        output req_fire, req_id, req_len, req_size,
        output cpl_valid, cpl_id, cpl_data, cpl_keep, cpl_last,
        input  cpl_ready, req_data, req_valid, busy, err_id, err_ovf, err_tout
    );

    modport slave (
        input  req_fire, req_id, req_len, req_size,
        input  cpl_valid, cpl_id, cpl_data, cpl_keep, cpl_last,
        output cpl_ready, req_data, req_valid, busy, err_id, err_ovf, err_tout
    );
endinterface

// File: rtl/qemu_rd_cpl_assembler.sv
// Assembles QEMU read-completion chunks into a byte buffer for the AXI4 slave read stage,
// with sticky ID-mismatch, overflow and timeout flags.
module qemu_rd_cpl_assembler #(
    parameter int TAGW = 3,
    parameter int CHW  = 64,
    parameter int DTMP = 4096,
    parameter int TOUT = 65535
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    qemu_rd_cpl_assembler_if.slave bus
);
    localparam int          NB     = CHW / 8;
    localparam int          AW     = (DTMP > 1) ? $clog2(DTMP) : 1;
    localparam logic [12:0] DTMP13 = 13'(DTMP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DELIVER
    } state_e;

    state_e          state_q, state_d;
    logic [TAGW-1:0] id_q, id_d;
    logic [12:0]     exp_q, exp_d;
    logic [12:0]     wptr_q, wptr_d;
    logic [15:0]     tcnt_q, tcnt_d;
    logic            err_id_q, err_id_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_tout_q, err_tout_d;
    logic [7:0]      buf_q [DTMP];
    logic [7:0]      buf_d [DTMP];

    logic [12:0]     exp_raw;
    logic [13:0]     addr;
    logic [13:0]     wsum;

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        exp_d      = exp_q;
        wptr_d     = wptr_q;
        tcnt_d     = tcnt_q;
        err_id_d   = err_id_q;
        err_ovf_d  = err_ovf_q;
        err_tout_d = err_tout_q;
        buf_d      = buf_q;
        addr       = '0;
        wsum       = '0;
        // Byte count wraps in 13 bits before the clamp, matching the host model's arithmetic.
        exp_raw    = (13'(bus.req_len) + 13'd1) << bus.req_size;

        case (state_q)
            S_IDLE: begin
                if (bus.req_fire) begin
                    id_d    = bus.req_id;
                    exp_d   = (exp_raw > DTMP13) ? DTMP13 : exp_raw;
                    wptr_d  = '0;
                    tcnt_d  = '0;
                    for (int i = 0; i < DTMP; i++) buf_d[i] = 8'h00;
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (bus.cpl_valid) begin
                    tcnt_d = '0;
                    if (bus.cpl_id != id_q) begin
                        err_id_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NB; i++) begin
                            addr = {1'b0, wptr_q} + 14'(i);
                            if (bus.cpl_keep[i]) begin
                                if (addr < {1'b0, exp_q}) buf_d[addr[AW-1:0]] = bus.cpl_data[i*8 +: 8];
                                else                      err_ovf_d = 1'b1;
                            end
                        end
                        wsum   = {1'b0, wptr_q} + 14'(NB);
                        wptr_d = (wsum >= {1'b0, exp_q}) ? exp_q : wsum[12:0];
                        if (bus.cpl_last || (wsum >= {1'b0, exp_q})) state_d = S_DELIVER;
                    end
                end else if (tcnt_q == 16'(TOUT - 1)) begin
                    err_tout_d = 1'b1;
                    state_d    = S_DELIVER;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end

            S_DELIVER: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the buffer is part of the reset domain because consumers expect it to read zero after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            exp_q      <= '0;
            wptr_q     <= '0;
            tcnt_q     <= '0;
            err_id_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_tout_q <= 1'b0;
            for (int i = 0; i < DTMP; i++) buf_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            exp_q      <= exp_d;
            wptr_q     <= wptr_d;
            tcnt_q     <= tcnt_d;
            err_id_q   <= err_id_d;
            err_ovf_q  <= err_ovf_d;
            err_tout_q <= err_tout_d;
            buf_q      <= buf_d;
        end
    end

    // Handshake outputs come straight from state so cpl_ready never depends on cpl_valid.
    assign bus.cpl_ready = (state_q == S_COLLECT);
    assign bus.req_valid = (state_q == S_DELIVER);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err_id    = err_id_q;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_tout  = err_tout_q;
    assign bus.req_data  = buf_q;
endmodule
